// File: rtl/fsml_stream_controller_if.sv
// Word/result handshake and serial detector link between host, controller and fsml detector.
interface fsml_stream_controller_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              In_valid;
  logic              In_ready;
  logic [WORD_W-1:0] In_data;
  logic              Ser_out;
  logic              Ser_valid;
  logic              Det_rst;
  logic              Det_in;
  logic              Res_valid;
  logic              Res_ready;
  logic [CNT_W-1:0]  Res_count;
  logic              Res_any;

  // Host/detector side of the link
  modport master (
    output In_valid, In_data, Res_ready, Det_in,
    input  In_ready, Ser_out, Ser_valid, Det_rst, Res_valid, Res_count, Res_any
  );

  // Controller side of the link
  modport slave (
    input  In_valid, In_data, Res_ready, Det_in,
    output In_ready, Ser_out, Ser_valid, Det_rst, Res_valid, Res_count, Res_any
  );
endinterface

// File: rtl/fsml_stream_controller.sv
// Serializes host words MSB-first into the fsml detector and reports per-word match counts.
// Optional macro FSML_DET_CLEAR_EN: one CLR cycle after accept pulses Det_rst so each word starts clean.
module fsml_stream_controller #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DET_LAT = 1
) (
  input  logic Clock,
  input  logic Reset,
  fsml_stream_controller_if.slave bus
);

  localparam int unsigned WIN_W      = $clog2(WORD_W + DET_LAT + 1);
  localparam int unsigned SHIFT_LAST = WORD_W - 1;
  localparam int unsigned DRAIN_LAST = WORD_W + DET_LAT - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef FSML_DET_CLEAR_EN
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  res_count_q;
  logic              res_any_q;
  logic              res_valid_q;
  logic              in_ready_q;
  logic              ser_out_q;
  logic              ser_valid_q;
  logic              in_window;
  logic              report_load;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    win_d     = win_q;
    acc_d     = acc_q;
    in_window = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.In_valid && in_ready_q) begin
          shreg_d = bus.In_data;
          win_d   = '0;
          acc_d   = '0;
`ifdef FSML_DET_CLEAR_EN
          state_d = CLR;
`else
          state_d = SHIFT;
`endif
        end
      end
`ifdef FSML_DET_CLEAR_EN
      CLR: state_d = SHIFT;
`endif
      SHIFT: begin
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        win_d     = win_q + WIN_W'(1);
        in_window = (win_q >= WIN_W'(DET_LAT));
        if (win_q == WIN_W'(SHIFT_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        win_d     = win_q + WIN_W'(1);
        in_window = (win_q >= WIN_W'(DET_LAT));
        if (win_q == WIN_W'(DRAIN_LAST)) state_d = REPORT;
      end
      REPORT: begin
        if (bus.Res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Saturating match accumulator
    if (in_window && bus.Det_in && (acc_q != CNT_MAX)) acc_d = acc_q + CNT_W'(1);

    report_load = (state_d == REPORT) && (state_q != REPORT);
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      res_count_q <= '0;
      res_any_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      res_valid_q <= (state_d == REPORT);
      in_ready_q  <= (state_d == IDLE);
      ser_valid_q <= (state_d == SHIFT);
      ser_out_q   <= (state_d == SHIFT) & shreg_d[WORD_W-1];
      if (report_load) begin
        res_count_q <= acc_d;
        res_any_q   <= (acc_d != '0);
      end
    end
  end

  assign bus.In_ready  = in_ready_q;
  assign bus.Ser_out   = ser_out_q;
  assign bus.Ser_valid = ser_valid_q;
  assign bus.Res_valid = res_valid_q;
  assign bus.Res_count = res_count_q;
  assign bus.Res_any   = res_any_q;

`ifdef FSML_DET_CLEAR_EN
  assign bus.Det_rst = Reset | (state_q == CLR);
`else
  assign bus.Det_rst = Reset;
`endif

endmodule

// File: tb/tb_fsml_stream_controller.sv
// Directed bench for fsml_stream_controller: delay-line detector model, two instances (CNT_W=4 and CNT_W=2).
module tb_fsml_stream_controller;

`ifdef FSML_DET_CLEAR_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic det_u = 1'b0;
  logic det_s = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   det_rst_extra = 0;
  int   seen_res = 0;
  int   accepts_u = 0;

  always #5 clk = ~clk;

  fsml_stream_controller_if #(.WORD_W(8), .CNT_W(4)) u ();
  fsml_stream_controller_if #(.WORD_W(8), .CNT_W(2)) s ();

  fsml_stream_controller #(.WORD_W(8), .CNT_W(4), .DET_LAT(1)) dut (
    .Clock(clk), .Reset(rst), .bus(u)
  );
  fsml_stream_controller #(.WORD_W(8), .CNT_W(2), .DET_LAT(1)) dut_sat (
    .Clock(clk), .Reset(rst), .bus(s)
  );

  // Detector model: Dout is Din delayed one clock
  always @(posedge clk) begin
    det_u <= u.Ser_out;
    det_s <= s.Ser_out;
  end
  assign u.Det_in = det_u;
  assign s.Det_in = det_s;

  always @(negedge clk) begin
    if (!rst && u.Det_rst) det_rst_extra++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; returns at the first Res_valid cycle
  task automatic serial_phase(input logic [7:0] w, input logic [3:0] exp_cnt);
`ifdef FSML_DET_CLEAR_EN
    check("clr_det_rst", 32'(u.Det_rst), 32'd1);
    check("clr_ser_valid", 32'(u.Ser_valid), 32'd0);
    tick();
`endif
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser_out_%0d", i), 32'(u.Ser_out), 32'(w[7-i]));
      check("ser_valid", 32'(u.Ser_valid), 32'd1);
      check("shift_in_ready", 32'(u.In_ready), 32'd0);
      check("shift_det_rst", 32'(u.Det_rst), 32'd0);
      tick();
    end
    check("drain_ser_valid", 32'(u.Ser_valid), 32'd0);
    check("drain_res_valid", 32'(u.Res_valid), 32'd0);
    tick();
    check("res_valid", 32'(u.Res_valid), 32'd1);
    check("res_count", 32'(u.Res_count), 32'(exp_cnt));
    check("res_any", 32'(u.Res_any), 32'(exp_cnt != 4'd0));
  endtask

  task automatic run_word(input logic [7:0] w, input logic [3:0] exp_cnt);
    check("pre_in_ready", 32'(u.In_ready), 32'd1);
    u.In_data  = w;
    u.In_valid = 1'b1;
    tick();
    accepts_u++;
    u.In_valid = 1'b0;
    serial_phase(w, exp_cnt);
  endtask

  initial begin
    u.In_valid = 1'b0; u.In_data = '0; u.Res_ready = 1'b0;
    s.In_valid = 1'b0; s.In_data = '0; s.Res_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(u.In_ready), 32'd0);
    check("rst_res_valid", 32'(u.Res_valid), 32'd0);
    check("rst_ser_valid", 32'(u.Ser_valid), 32'd0);
    check("rst_ser_out", 32'(u.Ser_out), 32'd0);
    check("rst_res_count", 32'(u.Res_count), 32'd0);
    check("rst_res_any", 32'(u.Res_any), 32'd0);
    check("rst_det_rst", 32'(u.Det_rst), 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(u.In_ready), 32'd1);
    check("post_rst_det_rst", 32'(u.Det_rst), 32'd0);

    // B5 with Res_ready high: five ones
    u.Res_ready = 1'b1;
    run_word(8'hB5, 4'd5);
    tick();
    check("b5_res_drop", 32'(u.Res_valid), 32'd0);
    check("b5_idle_ready", 32'(u.In_ready), 32'd1);
    check("b5_count_hold", 32'(u.Res_count), 32'd5);

    // All-zero word still reports
    run_word(8'h00, 4'd0);
    tick();
    check("z_res_drop", 32'(u.Res_valid), 32'd0);

    // Back-pressure on result while a second word waits
    u.Res_ready = 1'b0;
    run_word(8'h3C, 4'd4);
    u.In_data  = 8'hA1;
    u.In_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", 32'(u.Res_valid), 32'd1);
      check("hold_in_ready", 32'(u.In_ready), 32'd0);
      check("hold_count", 32'(u.Res_count), 32'd4);
      tick();
    end
    u.Res_ready = 1'b1;
    tick();
    check("rel_res_valid", 32'(u.Res_valid), 32'd0);
    check("rel_in_ready", 32'(u.In_ready), 32'd1);
    tick();
    accepts_u++;
    u.In_valid = 1'b0;
    serial_phase(8'hA1, 4'd3);
    tick();

    // Reset mid-SHIFT at bit 4 drops the word
    check("mid_pre_ready", 32'(u.In_ready), 32'd1);
    u.In_data  = 8'hFF;
    u.In_valid = 1'b1;
    tick();
    accepts_u++;
    u.In_valid = 1'b0;
`ifdef FSML_DET_CLEAR_EN
    tick();
`endif
    repeat (4) tick();
    check("mid_bit4_valid", 32'(u.Ser_valid), 32'd1);
    check("mid_bit4_out", 32'(u.Ser_out), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_ser_valid", 32'(u.Ser_valid), 32'd0);
    check("mid_rst_det_rst", 32'(u.Det_rst), 32'd1);
    check("mid_rst_res_count", 32'(u.Res_count), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_idle_ready", 32'(u.In_ready), 32'd1);
    check("mid_idle_ser_valid", 32'(u.Ser_valid), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (u.Res_valid) seen_res++;
      tick();
    end
    check("mid_no_result", 32'(seen_res), 32'd0);

    // Saturation on the CNT_W=2 instance
    check("sat_pre_ready", 32'(s.In_ready), 32'd1);
    s.In_data  = 8'hFF;
    s.In_valid = 1'b1;
    tick();
    s.In_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("sat_early_valid", 32'(s.Res_valid), 32'd0);
    tick();
    check("sat_res_valid", 32'(s.Res_valid), 32'd1);
    check("sat_count", 32'(s.Res_count), 32'd3);
    check("sat_any", 32'(s.Res_any), 32'd1);

`ifdef FSML_DET_CLEAR_EN
    check("det_rst_pulses", 32'(det_rst_extra), 32'(accepts_u));
`else
    check("det_rst_outside_reset", 32'(det_rst_extra), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsml_stream_controller.md
Name: fsml_stream_controller

Overview:
Sequencer that feeds the serial sequence-detector FSM (the fsml family) from a parallel word stream. It accepts a WORD_W-bit word over a valid/ready handshake and shifts it MSB-first into the detector's Din. It samples the detector's Dout over the aligned window and returns a per-word match count over a second valid/ready handshake. The block sits between a word-oriented host and the bit-serial detector.

Parameters:
WORD_W, 8, bits per word serialized; range 2..32.
CNT_W, 4, match-count width; must satisfy 2^CNT_W-1 >= WORD_W, else the count saturates.
DET_LAT, 1, detector latency in clocks, from the edge that samples Ser_out to the cycle where Dout reflects that bit; range 1..4.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
In_valid  input  1  host word valid.
In_ready  output  1  controller can accept a word.
In_data  input  WORD_W  word to serialize.
Ser_out  output  1  serial bit to detector Din.
Ser_valid  output  1  Ser_out carries a word bit this cycle.
Det_rst  output  1  reset to detector, active-high.
Det_in  input  1  detector Dout.
Res_valid  output  1  result available.
Res_ready  input  1  host takes result.
Res_count  output  CNT_W  number of cycles Det_in=1 within the sample window.
Res_any  output  1  Res_count != 0.

Behaviour:
- One clock (Clock). Reset is synchronous and active-high; all state updates on rising edge only.
- Reset values: state IDLE, shift reg 0, bit/window counters 0, Res_count 0, Res_any 0, Res_valid 0, Ser_out 0, Ser_valid 0. In_ready=1 from the first edge after Reset deasserts. Det_rst=1 while Reset=1.
- States: IDLE, (CLR, only with the optional feature), SHIFT, DRAIN, REPORT.
- IDLE: In_ready=1. On In_valid&&In_ready, load In_data into the shift reg, clear counters, then go to SHIFT (or CLR). No other state asserts In_ready.
- SHIFT: exactly WORD_W cycles. Ser_out=shreg[WORD_W-1], Ser_valid=1, and the shift reg shifts left each cycle, 0 filled. After WORD_W cycles, go to DRAIN. Ser_out=0 and Ser_valid=0 in every other state.
- DRAIN: exactly DET_LAT cycles, Ser_valid=0. Then go to REPORT.
- Sampling: a window index w counts cycles from the first SHIFT cycle (w=0). Det_in is sampled when DET_LAT <= w <= WORD_W-1+DET_LAT, giving exactly WORD_W samples. Each sampled 1 increments the match count, which saturates at 2^CNT_W-1 with no wrap.
- REPORT: Res_valid=1. Res_count and Res_any are registered and stable while Res_valid=1 and Res_ready=0. On Res_ready=1, go to IDLE in the same edge; Res_valid drops next cycle. Res_count and Res_any hold their values until the next REPORT.
- Latency: Res_valid rises WORD_W+DET_LAT edges after the accept edge (+1 with the optional feature). Minimum word period is WORD_W+DET_LAT+2 cycles.
- Reset mid-operation (any state): next state IDLE, the in-flight word is dropped, no result is produced, and Res_valid=0.
- In_valid during non-IDLE states is ignored and the host holds the word. Res_ready is ignored outside REPORT.
- Without the optional feature, the detector state persists across words, so matches may span word boundaries.

Optional Feature:
Macro FSML_DET_CLEAR_EN.
- Defined: after accept, the controller enters CLR for 1 cycle. It asserts Det_rst=1 during CLR (OR'd with Reset), then goes to SHIFT. Each word starts from detector reset, and latency increases by 1.
- Undefined: the CLR state does not exist, Det_rst equals Reset, and detector history carries between words.

Test Plan:
- Bench detector model Det_in = Ser_out delayed 1 clk; word 8'hB5 with Res_ready=1 -> Ser_out sequence 1,0,1,1,0,1,0,1; Res_valid rises 9 edges after accept; Res_count=5, Res_any=1.
- Word 8'h00 -> Res_count=0, Res_any=0, Res_valid still asserted at the same latency.
- CNT_W=2, word 8'hFF -> Res_count saturates at 3, no wrap; Res_any=1.
- Res_ready held 0 for 5 cycles in REPORT, In_valid=1 with a second word -> In_ready=0, Res_count stable; the second word is accepted 1 cycle after Res_ready=1.
- Reset=1 for one cycle mid-SHIFT (bit 4) -> next cycle IDLE, Ser_valid=0, In_ready=1; no Res_valid for the dropped word.
- With FSML_DET_CLEAR_EN defined -> Det_rst=1 for exactly one cycle after accept, Res_valid rises 10 edges after accept. Without it -> Det_rst never rises outside Reset.
